// File: rtl/write_back_retire_unit_if.sv
// Write-back bus between the end of the pipeline and the retire unit, including
// the register-file write port, the halt/report handshake and the performance counters.
interface write_back_retire_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 5,
  parameter int SEL_W      = $clog2(NUM_SRC),
  parameter int CNT_WIDTH  = 32
);
  logic                          i_valid;
  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data;
  logic [SEL_W-1:0]              i_result_src;
  logic [REG_ADDR_W-1:0]         i_rd_addr;
  logic                          i_reg_we;
  logic                          i_ecall_instr;
  logic [3:0]                    i_cause;
  logic [DATA_WIDTH-1:0]         i_a0_data;
  logic                          i_branch_instr;
  logic                          i_branch_mispred;
  logic                          i_report_ack;

  logic [DATA_WIDTH-1:0]         o_result;
  logic [REG_ADDR_W-1:0]         o_rd_addr;
  logic                          o_reg_we;
  logic                          o_halt;
  logic                          o_report_valid;
  logic [7:0]                    o_exit_code;
  logic [3:0]                    o_cause;
  logic [CNT_WIDTH-1:0]          o_instret;
  logic [CNT_WIDTH-1:0]          o_cycles;
  logic [CNT_WIDTH-1:0]          o_branch_total;
  logic [CNT_WIDTH-1:0]          o_branch_mispred;

  modport master (
    output i_valid, i_src_data, i_result_src, i_rd_addr, i_reg_we, i_ecall_instr,
           i_cause, i_a0_data, i_branch_instr, i_branch_mispred, i_report_ack,
    input  o_result, o_rd_addr, o_reg_we, o_halt, o_report_valid, o_exit_code,
           o_cause, o_instret, o_cycles, o_branch_total, o_branch_mispred
  );

  modport slave (
    input  i_valid, i_src_data, i_result_src, i_rd_addr, i_reg_we, i_ecall_instr,
           i_cause, i_a0_data, i_branch_instr, i_branch_mispred, i_report_ack,
    output o_result, o_rd_addr, o_reg_we, o_halt, o_report_valid, o_exit_code,
           o_cause, o_instret, o_cycles, o_branch_total, o_branch_mispred
  );
endinterface

// File: rtl/write_back_retire_unit.sv
// Write-back and retirement stage: result-source mux, saturating performance counters
// and the RUN -> REPORT -> HALTED sequence triggered by a retiring ecall.
module write_back_retire_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 5,
  parameter int SEL_W      = $clog2(NUM_SRC),
  parameter int CNT_WIDTH  = 32
) (
  input logic                    i_clk,
  input logic                    i_arst,
  write_back_retire_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REPORT,
    ST_HALTED
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            exit_code_q, exit_code_d;
  logic [3:0]            cause_q, cause_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;
  logic [CNT_WIDTH-1:0]  cycles_q, cycles_d;
  logic [CNT_WIDTH-1:0]  br_total_q, br_total_d;
  logic [CNT_WIDTH-1:0]  br_mispred_q, br_mispred_d;
  logic [DATA_WIDTH-1:0] result;
  logic                  run;
  logic                  retire;

  // ADDR_WIDTH is informational and the exit code only needs a0[7:0].
  localparam int unused_addr_w = ADDR_WIDTH;
  logic unused_a0_hi;
  assign unused_a0_hi = ^bus.i_a0_data[DATA_WIDTH-1:8];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Out-of-range selects match no source and leave the result at zero.
  always_comb begin
    result = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.i_result_src == SEL_W'(k)) result = bus.i_src_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign run    = (state_q == ST_RUN);
  assign retire = run & bus.i_valid;

  // NOTE: every always_comb output takes its default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    exit_code_d  = exit_code_q;
    cause_d      = cause_q;
    instret_d    = instret_q;
    cycles_d     = cycles_q;
    br_total_d   = br_total_q;
    br_mispred_d = br_mispred_q;

    unique case (state_q)
      ST_RUN: begin
        cycles_d = sat_inc(cycles_q);
        if (retire) instret_d = sat_inc(instret_q);
        if (retire && bus.i_branch_instr) br_total_d = sat_inc(br_total_q);
        if (retire && bus.i_branch_instr && bus.i_branch_mispred)
          br_mispred_d = sat_inc(br_mispred_q);
        if (retire && bus.i_ecall_instr) begin
          exit_code_d = bus.i_a0_data[7:0];
          cause_d     = bus.i_cause;
          state_d     = ST_REPORT;
        end
      end
      ST_REPORT: if (bus.i_report_ack) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_HALTED;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the async reset clears it without a clock.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q      <= ST_RUN;
      exit_code_q  <= '0;
      cause_q      <= '0;
      instret_q    <= '0;
      cycles_q     <= '0;
      br_total_q   <= '0;
      br_mispred_q <= '0;
    end else begin
      state_q      <= state_d;
      exit_code_q  <= exit_code_d;
      cause_q      <= cause_d;
      instret_q    <= instret_d;
      cycles_q     <= cycles_d;
      br_total_q   <= br_total_d;
      br_mispred_q <= br_mispred_d;
    end
  end

  assign bus.o_result         = result;
  assign bus.o_rd_addr        = bus.i_rd_addr;
  assign bus.o_reg_we         = retire & bus.i_reg_we & ~bus.i_ecall_instr;
  assign bus.o_halt           = ~run;
  assign bus.o_report_valid   = (state_q == ST_REPORT);
  assign bus.o_exit_code      = exit_code_q;
  assign bus.o_cause          = cause_q;
  assign bus.o_instret        = instret_q;
  assign bus.o_cycles         = cycles_q;
  assign bus.o_branch_total   = br_total_q;
  assign bus.o_branch_mispred = br_mispred_q;

endmodule

// File: tb/tb_write_back_retire_unit.sv
// Directed bench for write_back_retire_unit: expectations are queued as stimulus is
// driven and popped against the DUT outputs; a second instance uses 4-bit counters.
module tb_write_back_retire_unit;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  write_back_retire_unit_if #(.DATA_WIDTH(64), .REG_ADDR_W(5), .NUM_SRC(5), .CNT_WIDTH(32)) a_if ();
  write_back_retire_unit_if #(.DATA_WIDTH(64), .REG_ADDR_W(5), .NUM_SRC(5), .CNT_WIDTH(4))  b_if ();

  write_back_retire_unit #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .REG_ADDR_W(5), .NUM_SRC(5), .CNT_WIDTH(32)
  ) dut_a (
    .i_clk (clk),
    .i_arst(arst),
    .bus   (a_if.slave)
  );

  write_back_retire_unit #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .REG_ADDR_W(5), .NUM_SRC(5), .CNT_WIDTH(4)
  ) dut_b (
    .i_clk (clk),
    .i_arst(arst),
    .bus   (b_if.slave)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push_exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty: observed=0x%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic push_state(input string tag, input logic halt, input logic rv,
                            input logic [7:0] ex, input logic [3:0] ca,
                            input logic [31:0] ir, input logic [31:0] cy,
                            input logic [31:0] bt, input logic [31:0] bm);
    push_exp({tag, ".halt"}, 64'(halt));
    push_exp({tag, ".report_valid"}, 64'(rv));
    push_exp({tag, ".exit_code"}, 64'(ex));
    push_exp({tag, ".cause"}, 64'(ca));
    push_exp({tag, ".instret"}, 64'(ir));
    push_exp({tag, ".cycles"}, 64'(cy));
    push_exp({tag, ".branch_total"}, 64'(bt));
    push_exp({tag, ".branch_mispred"}, 64'(bm));
  endtask

  task automatic check_state();
    pop_check(64'(a_if.o_halt));
    pop_check(64'(a_if.o_report_valid));
    pop_check(64'(a_if.o_exit_code));
    pop_check(64'(a_if.o_cause));
    pop_check(64'(a_if.o_instret));
    pop_check(64'(a_if.o_cycles));
    pop_check(64'(a_if.o_branch_total));
    pop_check(64'(a_if.o_branch_mispred));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_if.i_valid          = 1'b0;
    a_if.i_reg_we         = 1'b0;
    a_if.i_ecall_instr    = 1'b0;
    a_if.i_branch_instr   = 1'b0;
    a_if.i_branch_mispred = 1'b0;
    a_if.i_report_ack     = 1'b0;
  endtask

  // Called just after a clock edge; reset is asserted and released between edges.
  task automatic do_reset();
    arst = 1'b1;
    #1;
    arst = 1'b0;
  endtask

  // Counting table: {valid, branch, mispred}; 10 valid, 4 branches, 1 mispredict.
  logic [2:0] cnt_tab [13] = '{
    3'b100, 3'b110, 3'b011, 3'b101, 3'b111, 3'b100, 3'b000,
    3'b110, 3'b100, 3'b000, 3'b110, 3'b100, 3'b100
  };

  initial begin
    idle_a();
    a_if.i_src_data   = '0;
    a_if.i_result_src = '0;
    a_if.i_rd_addr    = '0;
    a_if.i_cause      = '0;
    a_if.i_a0_data    = '0;
    b_if.i_valid          = 1'b0;
    b_if.i_src_data       = '0;
    b_if.i_result_src     = '0;
    b_if.i_rd_addr        = '0;
    b_if.i_reg_we         = 1'b0;
    b_if.i_ecall_instr    = 1'b0;
    b_if.i_cause          = '0;
    b_if.i_a0_data        = '0;
    b_if.i_branch_instr   = 1'b0;
    b_if.i_branch_mispred = 1'b0;
    b_if.i_report_ack     = 1'b0;

    // Reset state, before any clock edge
    #1 arst = 1'b1;
    #1;
    push_state("reset", 1'b0, 1'b0, 8'h00, 4'h0, 0, 0, 0, 0);
    check_state();
    tick();
    arst = 1'b0;

    // Mux sweep: select 0..4 picks source k, 5..7 yields zero
    for (int k = 0; k < 5; k++) a_if.i_src_data[k*64 +: 64] = 64'h1111_0000 + 64'(k);
    tick();
    for (int s = 0; s < 8; s++) begin
      a_if.i_result_src = 3'(s);
      push_exp($sformatf("mux_sel%0d", s), (s < 5) ? 64'h1111_0000 + 64'(s) : 64'h0);
      #1;
      pop_check(a_if.o_result);
    end

    // Ordinary write path
    tick();
    a_if.i_valid   = 1'b1;
    a_if.i_reg_we  = 1'b1;
    a_if.i_rd_addr = 5'd7;
    push_exp("reg_we_write", 64'h1);
    push_exp("rd_addr_pass", 64'd7);
    #1;
    pop_check(64'(a_if.o_reg_we));
    pop_check(64'(a_if.o_rd_addr));
    a_if.i_reg_we = 1'b0;
    push_exp("reg_we_no_we", 64'h0);
    #1;
    pop_check(64'(a_if.o_reg_we));

    // Counting: 13 cycles from a fresh reset
    tick();
    idle_a();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      a_if.i_valid          = cnt_tab[i][2];
      a_if.i_branch_instr   = cnt_tab[i][1];
      a_if.i_branch_mispred = cnt_tab[i][0];
      tick();
    end
    idle_a();
    push_state("count", 1'b0, 1'b0, 8'h00, 4'h0, 10, 13, 4, 1);
    check_state();

    // Ecall retires with branch+mispred flags and a (ignored) ack in RUN
    a_if.i_valid          = 1'b1;
    a_if.i_reg_we         = 1'b1;
    a_if.i_ecall_instr    = 1'b1;
    a_if.i_a0_data        = 64'h1FF;
    a_if.i_cause          = 4'hB;
    a_if.i_branch_instr   = 1'b1;
    a_if.i_branch_mispred = 1'b1;
    a_if.i_report_ack     = 1'b1;
    push_exp("ecall_reg_we", 64'h0);
    #1;
    pop_check(64'(a_if.o_reg_we));
    tick();
    push_state("ecall_next", 1'b1, 1'b1, 8'hFF, 4'hB, 11, 14, 5, 2);
    check_state();

    // Further instructions while reporting do not count or write; ack held off 5 cycles
    a_if.i_report_ack  = 1'b0;
    a_if.i_ecall_instr = 1'b0;
    a_if.i_a0_data     = 64'h0;
    a_if.i_cause       = 4'h0;
    push_exp("report_reg_we", 64'h0);
    #1;
    pop_check(64'(a_if.o_reg_we));
    repeat (5) tick();
    push_state("report_hold", 1'b1, 1'b1, 8'hFF, 4'hB, 11, 14, 5, 2);
    check_state();
    a_if.i_report_ack = 1'b1;
    tick();
    a_if.i_report_ack = 1'b0;
    push_state("after_ack", 1'b1, 1'b0, 8'hFF, 4'hB, 11, 14, 5, 2);
    check_state();

    // HALTED ignores new ecalls and acks
    a_if.i_ecall_instr = 1'b1;
    a_if.i_cause       = 4'h2;
    a_if.i_report_ack  = 1'b1;
    repeat (2) tick();
    push_state("halted", 1'b1, 1'b0, 8'hFF, 4'hB, 11, 14, 5, 2);
    check_state();

    // Ack in the first REPORT cycle is accepted at that edge
    idle_a();
    do_reset();
    push_state("reset2", 1'b0, 1'b0, 8'h00, 4'h0, 0, 0, 0, 0);
    check_state();
    a_if.i_valid       = 1'b1;
    a_if.i_ecall_instr = 1'b1;
    a_if.i_a0_data     = 64'h42;
    a_if.i_cause       = 4'h3;
    tick();
    idle_a();
    a_if.i_report_ack = 1'b1;
    push_exp("first_report_rv", 64'h1);
    pop_check(64'(a_if.o_report_valid));
    tick();
    a_if.i_report_ack = 1'b0;
    push_state("fast_ack", 1'b1, 1'b0, 8'h42, 4'h3, 1, 1, 0, 0);
    check_state();

    // Asynchronous reset in the middle of REPORT
    do_reset();
    a_if.i_valid       = 1'b1;
    a_if.i_ecall_instr = 1'b1;
    a_if.i_a0_data     = 64'h17;
    a_if.i_cause       = 4'h5;
    tick();
    idle_a();
    push_exp("pre_reset_rv", 64'h1);
    pop_check(64'(a_if.o_report_valid));
    #2 arst = 1'b1;
    #1;
    push_state("mid_report_reset", 1'b0, 1'b0, 8'h00, 4'h0, 0, 0, 0, 0);
    check_state();
    arst = 1'b0;
    a_if.i_valid   = 1'b1;
    a_if.i_reg_we  = 1'b1;
    a_if.i_rd_addr = 5'd9;
    push_exp("post_reset_we", 64'h1);
    #1;
    pop_check(64'(a_if.o_reg_we));
    tick();
    idle_a();
    push_exp("post_reset_instret", 64'd1);
    pop_check(64'(a_if.o_instret));

    // Saturation on the 4-bit-counter instance
    b_if.i_valid        = 1'b1;
    b_if.i_branch_instr = 1'b1;
    repeat (14) tick();
    push_exp("sat_b_instret_14", 64'd14);
    pop_check(64'(b_if.o_instret));
    repeat (6) tick();
    b_if.i_valid        = 1'b0;
    b_if.i_branch_instr = 1'b0;
    push_exp("sat_b_instret", 64'd15);
    push_exp("sat_b_cycles", 64'd15);
    push_exp("sat_b_branch_total", 64'd15);
    pop_check(64'(b_if.o_instret));
    pop_check(64'(b_if.o_cycles));
    pop_check(64'(b_if.o_branch_total));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
